// File: rtl/pot_quantizer_if.sv
// Handshake bundle for pot_quantizer: value in, power-of-two weight code out.
interface pot_quantizer_if #(
    parameter int WEIGHT_BIT_WIDTH = 4,
    parameter int VALUE_BIT_WIDTH  = 12
) ();
    logic                        in_valid;
    logic                        in_ready;
    logic [VALUE_BIT_WIDTH-1:0]  in;
    logic                        out_valid;
    logic                        out_ready;
    logic [WEIGHT_BIT_WIDTH-1:0] weight;
    logic                        zero;
    logic                        saturated;

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, weight, zero, saturated
    );

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, weight, zero, saturated
    );
endinterface

// File: rtl/pot_quantizer.sv
// Quantizes a signed value to a sign + exponent power-of-two code by a leading-one scan.
// Define POT_QUANTIZER_ROUND_EN for round-to-nearest; otherwise the exponent truncates.
module pot_quantizer #(
    parameter int WEIGHT_BIT_WIDTH = 4,
    parameter int VALUE_BIT_WIDTH  = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    pot_quantizer_if.slave bus
);
    localparam int IDX_W = $clog2(VALUE_BIT_WIDTH);
    localparam int EXP_W = WEIGHT_BIT_WIDTH - 1;
    localparam int R_W   = (IDX_W + 1 > EXP_W) ? IDX_W + 2 : EXP_W + 1;
    localparam int EMAX  = (1 << EXP_W) - 1;
    localparam logic [R_W-1:0]   EMAX_R  = R_W'(EMAX);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(VALUE_BIT_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state_r;
    logic [VALUE_BIT_WIDTH-1:0]  mag_r;
    logic                        sign_r;
    logic [IDX_W-1:0]            idx_r;
    logic                        in_ready_r;
    logic                        out_valid_r;
    logic [WEIGHT_BIT_WIDTH-1:0] weight_r;
    logic                        zero_r;
    logic                        sat_r;

    logic [VALUE_BIT_WIDTH-1:0]  abs_s;
    logic                        round_s;
    logic [R_W-1:0]              r_s;
    logic                        sat_s;
    logic [EXP_W-1:0]            exp_s;

`ifdef POT_QUANTIZER_ROUND_EN
    // Bit just below the leading one decides the round-up; nothing below bit 0.
    function automatic logic bit_below(input logic [VALUE_BIT_WIDTH-1:0] m,
                                       input logic [IDX_W-1:0] i);
        logic b;
        if (i == '0) begin
            b = 1'b0;
        end else begin
            b = m[i - IDX_W'(1)];
        end
        return b;
    endfunction
`endif

    // Magnitude of the incoming value; the most negative value maps to 2^(N-1).
    always_comb begin
        if (bus.in[VALUE_BIT_WIDTH-1]) begin
            abs_s = ~bus.in + VALUE_BIT_WIDTH'(1);
        end else begin
            abs_s = bus.in;
        end
    end

    // Rounded exponent for the current scan position, clipped to EMAX.
    always_comb begin
`ifdef POT_QUANTIZER_ROUND_EN
        round_s = bit_below(mag_r, idx_r);
`else
        round_s = 1'b0;
`endif
        r_s = R_W'(idx_r) + R_W'(round_s);
        if (r_s > EMAX_R) begin
            sat_s = 1'b1;
            exp_s = EMAX_R[EXP_W-1:0];
        end else begin
            sat_s = 1'b0;
            exp_s = r_s[EXP_W-1:0];
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mag_r       <= '0;
            sign_r      <= 1'b0;
            idx_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            weight_r    <= '0;
            zero_r      <= 1'b0;
            sat_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        mag_r      <= abs_s;
                        sign_r     <= bus.in[VALUE_BIT_WIDTH-1];
                        idx_r      <= IDX_TOP;
                        in_ready_r <= 1'b0;
                        state_r    <= SCAN;
                    end
                end
                SCAN: begin
                    if (mag_r[idx_r]) begin
                        weight_r    <= {sign_r, exp_s};
                        zero_r      <= 1'b0;
                        sat_r       <= sat_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else if (idx_r == '0) begin
                        weight_r    <= '0;
                        zero_r      <= 1'b1;
                        sat_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        idx_r <= idx_r - IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.weight    = weight_r;
    assign bus.zero      = zero_r;
    assign bus.saturated = sat_r;
endmodule

// File: tb/tb_pot_quantizer.sv
// Directed bench for pot_quantizer with a cycle-level reference model and per-cycle compare.
module tb_pot_quantizer;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    pot_quantizer_if #(.WEIGHT_BIT_WIDTH(4), .VALUE_BIT_WIDTH(12)) bus ();
    pot_quantizer #(.WEIGHT_BIT_WIDTH(4), .VALUE_BIT_WIDTH(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef POT_QUANTIZER_ROUND_EN
    localparam logic [3:0] W12  = 4'h4;
    localparam logic [3:0] W3   = 4'h2;
    localparam logic [3:0] W100 = 4'h7;
    localparam logic       S192 = 1'b1;
`else
    localparam logic [3:0] W12  = 4'h3;
    localparam logic [3:0] W3   = 4'h1;
    localparam logic [3:0] W100 = 4'h6;
    localparam logic       S192 = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] w;
        logic       z;
        logic       s;
        logic [7:0] lat;
    } exp_t;

    // Expected result from plain arithmetic: floor(log2|v|), optional linear round-to-nearest.
    function automatic exp_t model(input int v);
        exp_t e;
        int   mag;
        int   p;
        int   r;
        mag = (v < 0) ? -v : v;
        if (mag == 0) begin
            e.w = 4'h0; e.z = 1'b1; e.s = 1'b0; e.lat = 8'd12;
        end else begin
            p = 0;
            while ((mag >> (p + 1)) != 0) p++;
            r = p;
`ifdef POT_QUANTIZER_ROUND_EN
            if (p > 0 && 2 * mag >= 3 * (1 << p)) r = p + 1;
`endif
            e.z   = 1'b0;
            e.s   = (r > 7);
            e.w   = {(v < 0) ? 1'b1 : 1'b0, 3'(e.s ? 7 : r)};
            e.lat = 8'(12 - p);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    // Reference model: idle / busy for the computed latency / holding a result.
    int   m_phase;
    int   m_cnt;
    exp_t m_exp;
    exp_t m_tmp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_exp   <= '0;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    m_tmp    = model(int'($signed(bus.in)));
                    m_exp   <= m_tmp;
                    m_cnt   <= int'(m_tmp.lat);
                    m_phase <= 1;
                end
                1: if (m_cnt == 1) m_phase <= 2; else m_cnt <= m_cnt - 1;
                2: if (bus.out_ready) m_phase <= 0;
                default: m_phase <= 0;
            endcase
        end
    end

    // Per-cycle compare of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_in_ready", 32'(bus.in_ready), 32'(m_phase == 0));
            chk("cyc_out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
            if (m_phase == 2) begin
                chk("cyc_weight", 32'(bus.weight), 32'(m_exp.w));
                chk("cyc_zero", 32'(bus.zero), 32'(m_exp.z));
                chk("cyc_sat", 32'(bus.saturated), 32'(m_exp.s));
            end
        end
    end

    // Handoff log used to spot dropped or duplicated results.
    logic [3:0] res_q[$];
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) res_q.push_back(bus.weight);
    end

    task automatic xact(input string nm, input int v, input logic [3:0] ew, input logic ez,
                        input logic es, input int elat, input int hold);
        int cyc;
        @(posedge clk); #1;
        chk({nm, "_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in        = 12'(v);
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, "_lat"}, 32'(cyc), 32'(elat));
        chk({nm, "_weight"}, 32'(bus.weight), 32'(ew));
        chk({nm, "_zero"}, 32'(bus.zero), 32'(ez));
        chk({nm, "_sat"}, 32'(bus.saturated), 32'(es));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({nm, "_hold_weight"}, 32'(bus.weight), 32'(ew));
            chk({nm, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        chk({nm, "_post_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   seen;
        exp_t e;
        bus.in_valid  = 1'b0;
        bus.in        = 12'd0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_weight", 32'(bus.weight), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd0);
        chk("rst_sat", 32'(bus.saturated), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Pin the model against hand-worked codes.
        e = model(12);    chk("model_p12", 32'(e.w), 32'(W12));
        e = model(-5);    chk("model_m5", 32'({e.w, e.lat}), 32'({4'hA, 8'd10}));
        e = model(-2048); chk("model_m2048", 32'({e.w, e.s, e.lat}), 32'({4'hF, 1'b1, 8'd1}));
        e = model(0);     chk("model_zero", 32'({e.w, e.z, e.lat}), 32'({4'h0, 1'b1, 8'd12}));

        xact("p12",   12,    W12,  1'b0, 1'b0, 9,  0);
        xact("m5",    -5,    4'hA, 1'b0, 1'b0, 10, 0);
        xact("zero",  0,     4'h0, 1'b1, 1'b0, 12, 0);
        xact("m2048", -2048, 4'hF, 1'b0, 1'b1, 1,  0);
        xact("p192",  192,   4'h7, 1'b0, S192, 5,  0);
        xact("p3",    3,     W3,   1'b0, 1'b0, 11, 5);

        // Back-to-back with in_valid held: +1 then -1.
        res_q.delete();
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in        = 12'd1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in = 12'hFFF;
        n = 0;
        while (res_q.size() < 1 && n < 40) begin @(posedge clk); #1; n++; end
        chk("b2b_first_done", 32'(n < 40), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (res_q.size() < 2 && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        chk("b2b_count", 32'(res_q.size()), 32'd2);
        if (res_q.size() == 2) begin
            chk("b2b_first", 32'(res_q[0]), 32'h0);
            chk("b2b_second", 32'(res_q[1]), 32'h8);
        end

        // Reset mid-scan discards the pending value.
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in        = 12'd100;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_weight", 32'(bus.weight), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        chk("mid_rst_no_out", 32'(seen), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        xact("p100", 100, W100, 1'b0, 1'b0, 6, 0);

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pot_quantizer.md
POT_QUANTIZER -- requirements
Module: pot_quantizer

Interface
REQ-001 The block SHALL have parameter WEIGHT_BIT_WIDTH, default 4, the width of the power-of-two weight code (1 sign bit plus a WEIGHT_BIT_WIDTH-1 bit exponent).
REQ-002 The block SHALL have parameter VALUE_BIT_WIDTH, default 12, the width of the signed two's-complement input value.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  input value present.
REQ-007 in_ready  output  1  block can accept a value.
REQ-008 in  input  VALUE_BIT_WIDTH  signed value to quantize.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 weight  output  WEIGHT_BIT_WIDTH  code: weight[MSB] is the sign (1 = negative); the low bits are the exponent e; the represented value is +/-2^e.
REQ-012 zero  output  1  input was 0.
REQ-013 saturated  output  1  exponent was clipped to EMAX = 2^(WEIGHT_BIT_WIDTH-1)-1.

Function
REQ-014 The FSM SHALL have the states IDLE, SCAN and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 In IDLE, in_valid=1 SHALL capture the sign of in and the magnitude |in| into a VALUE_BIT_WIDTH-bit unsigned register, with -2^(VALUE_BIT_WIDTH-1) giving magnitude 2^(VALUE_BIT_WIDTH-1), and SHALL move the FSM to SCAN.
REQ-016 SCAN SHALL examine one magnitude bit per cycle, with index idx starting at VALUE_BIT_WIDTH-1 and decrementing.
REQ-017 The FSM SHALL go to DONE on the first cycle in which mag[idx]=1 (leading-one position p=idx) or idx=0.
REQ-018 Latency SHALL be VALUE_BIT_WIDTH-p cycles from the acceptance edge to out_valid=1 for a nonzero input, and VALUE_BIT_WIDTH cycles for a zero input.
REQ-019 The rounded exponent SHALL be r = p+1 when rounding is enabled (see REQ-029) and mag[p-1]=1 with p>0; otherwise r = p.
REQ-020 If r > EMAX, the exponent SHALL be EMAX and saturated SHALL be 1; otherwise the exponent SHALL be r and saturated SHALL be 0.
REQ-021 A zero input SHALL produce weight=0, zero=1 and saturated=0.
REQ-022 A nonzero input SHALL produce zero=0, with the weight sign taken from the input sign.
REQ-023 weight, zero and saturated SHALL stay stable while out_valid=1.
REQ-024 The FSM SHALL leave DONE for IDLE on out_valid&&out_ready; in_ready SHALL rise on the next cycle, so the block accepts no new input in the same cycle as a result handoff.
REQ-025 in_valid SHALL be ignored outside IDLE.
REQ-026 out_ready SHALL be ignored outside DONE.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, out_valid=0, weight=0, zero=0 and saturated=0; in_ready SHALL be 1 while rst_n=1 and the FSM is in IDLE.
REQ-028 Reset during SCAN or DONE SHALL discard the pending value with no output handshake, and the first accept after reset SHALL behave per REQ-015.

Configuration
REQ-029 Macro POT_QUANTIZER_ROUND_EN defined SHALL give round-to-nearest in the linear domain per REQ-019, with ties at 1.5*2^p rounding up.
REQ-030 Macro POT_QUANTIZER_ROUND_EN undefined SHALL truncate (r = p always), and latency and handshake SHALL be unchanged.

Verification (VALUE_BIT_WIDTH=12, WEIGHT_BIT_WIDTH=4, EMAX=7)
REQ-031 in=+12, macro defined -> weight=0x4, zero=0, sat=0, out_valid 9 cycles after accept; macro undefined -> weight=0x3.
REQ-032 in=-5 -> weight=0xA, out_valid 10 cycles after accept; in=0 -> weight=0x0, zero=1, out_valid 12 cycles after accept.
REQ-033 in=-2048 -> weight=0xF, sat=1, out_valid 1 cycle after accept; in=+192 with macro defined -> weight=0x7, sat=1; macro undefined -> weight=0x7, sat=0.
REQ-034 in=+3 with out_ready held 0 for 5 cycles in DONE -> weight=0x2 held stable, in_ready=0 throughout, and one handoff when out_ready rises; in_ready=1 on the following cycle.
REQ-035 Back-to-back in_valid=1 with in=+1 then in=-1 and out_ready=1 -> weight=0x0 then 0x8, each with latency 12, and no value dropped or duplicated.
REQ-036 rst_n pulsed low mid-SCAN for in=+100 -> out_valid never asserts for that value, in_ready=1 after release, and a next in=+100 gives weight=0x7 (macro defined) after 6 cycles.
